// File: rtl/rbm_iteration_scheduler.sv
// Drives one shared RBM layer engine through hidden/classify passes for a configured
// number of stochastic iterations, accumulates saturated classify sums and reports the argmax class.
module rbm_iteration_scheduler #(
  parameter int                  bitlength      = 12,
  parameter int                  output_dim     = 2,
  parameter int                  idx_width      = 1,
  parameter logic [bitlength-1:0] Inf           = 12'b0111_1111_1111,
  parameter int                  iter_width     = 8,
  parameter int                  timeout_cycles = 1024
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [iter_width-1:0]             iter_cfg,
  output logic                              layer_reset,
  output logic                              layer_start,
  output logic                              layer_sel,
  input  logic                              layer_done,
  input  logic [output_dim*bitlength-1:0]   layer_out,
  output logic [output_dim*bitlength-1:0]   out_data,
  output logic [idx_width-1:0]              class_idx,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              error,
  output logic                              busy
);

  localparam int wd_width = $clog2(timeout_cycles + 1);
  localparam logic [wd_width-1:0] wd_last = wd_width'(timeout_cycles - 1);
  localparam logic signed [bitlength:0] pos_lim = $signed({1'b0, Inf});
  localparam logic signed [bitlength:0] neg_lim = -pos_lim;
  localparam logic [bitlength-1:0] neg_inf = neg_lim[bitlength-1:0];

  typedef enum logic [2:0] {
    IDLE, CLR, H_START, H_WAIT, C_START, C_WAIT, ACCUM, DONE
  } state_t;

  state_t state_q, state_d;
  logic [iter_width-1:0] target_q, target_d;
  logic [iter_width-1:0] iter_cnt_q, iter_cnt_d;
  logic [wd_width-1:0] wd_q, wd_d;
  logic [output_dim-1:0][bitlength-1:0] acc_q, acc_d;
  logic [output_dim-1:0][bitlength-1:0] sample_q, sample_d;
  logic [output_dim-1:0][bitlength-1:0] out_data_q, out_data_d;
  logic [output_dim-1:0][bitlength-1:0] acc_sat;
  logic [idx_width-1:0] class_idx_q, class_idx_d;
  logic [idx_width-1:0] best_idx;
  logic error_q, error_d;
  logic in_ready_q, in_ready_d;
  logic layer_reset_q, layer_reset_d;
  logic layer_start_q, layer_start_d;
  logic layer_sel_q, layer_sel_d;
  logic out_valid_q, out_valid_d;
  logic busy_q, busy_d;

  // Sum at one extra bit so the clamp sees the true value, never a wrapped one.
  always_comb begin
    logic signed [bitlength:0] sum_w;
    sum_w   = '0;
    acc_sat = '0;
    for (int g = 0; g < output_dim; g++) begin
      sum_w = $signed({acc_q[g][bitlength-1], acc_q[g]}) +
              $signed({sample_q[g][bitlength-1], sample_q[g]});
      if (sum_w > pos_lim)
        acc_sat[g] = Inf;
      else if (sum_w < neg_lim)
        acc_sat[g] = neg_inf;
      else
        acc_sat[g] = sum_w[bitlength-1:0];
    end
  end

  always_comb begin
    logic signed [bitlength-1:0] best_val;
    best_idx = '0;
    best_val = acc_d[0];
    for (int g = 1; g < output_dim; g++) begin
      if ($signed(acc_d[g]) > best_val) begin
        best_val = acc_d[g];
        best_idx = idx_width'(g);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    iter_cnt_d  = iter_cnt_q;
    wd_d        = wd_q;
    acc_d       = acc_q;
    sample_d    = sample_q;
    out_data_d  = out_data_q;
    class_idx_d = class_idx_q;
    error_d     = error_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          target_d    = (iter_cfg == '0) ? iter_width'(1) : iter_cfg;
          acc_d       = '0;
          iter_cnt_d  = '0;
          error_d     = 1'b0;
          class_idx_d = '0;
          state_d     = CLR;
        end
      end
      CLR: state_d = H_START;
      H_START: begin
        wd_d    = '0;
        state_d = H_WAIT;
      end
      H_WAIT: begin
        if (layer_done) begin
          state_d = C_START;
        end else if (wd_q == wd_last) begin
          error_d = 1'b1;
          state_d = DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      C_START: begin
        wd_d    = '0;
        state_d = C_WAIT;
      end
      C_WAIT: begin
        if (layer_done) begin
          sample_d = layer_out;
          state_d  = ACCUM;
        end else if (wd_q == wd_last) begin
          error_d = 1'b1;
          state_d = DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ACCUM: begin
        acc_d      = acc_sat;
        iter_cnt_d = iter_cnt_q + 1'b1;
        state_d    = (iter_cnt_d == target_q) ? DONE : CLR;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Results are captured once on the way into DONE and then held.
    if (state_d == DONE && state_q != DONE) begin
      out_data_d  = acc_d;
      class_idx_d = best_idx;
    end

    in_ready_d    = (state_d == IDLE);
    layer_reset_d = (state_d == CLR);
    layer_start_d = (state_d == H_START) || (state_d == C_START);
    layer_sel_d   = (state_d == C_START) || (state_d == C_WAIT);
    out_valid_d   = (state_d == DONE);
    busy_d        = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      target_q      <= '0;
      iter_cnt_q    <= '0;
      wd_q          <= '0;
      acc_q         <= '0;
      sample_q      <= '0;
      out_data_q    <= '0;
      class_idx_q   <= '0;
      error_q       <= 1'b0;
      in_ready_q    <= 1'b1;
      layer_reset_q <= 1'b0;
      layer_start_q <= 1'b0;
      layer_sel_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      iter_cnt_q    <= iter_cnt_d;
      wd_q          <= wd_d;
      acc_q         <= acc_d;
      sample_q      <= sample_d;
      out_data_q    <= out_data_d;
      class_idx_q   <= class_idx_d;
      error_q       <= error_d;
      in_ready_q    <= in_ready_d;
      layer_reset_q <= layer_reset_d;
      layer_start_q <= layer_start_d;
      layer_sel_q   <= layer_sel_d;
      out_valid_q   <= out_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign layer_reset = layer_reset_q;
  assign layer_start = layer_start_q;
  assign layer_sel   = layer_sel_q;
  assign out_data    = out_data_q;
  assign class_idx   = class_idx_q;
  assign out_valid   = out_valid_q;
  assign error       = error_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_rbm_iteration_scheduler.sv
// Directed bench for rbm_iteration_scheduler: a one-cycle-latency engine model answers
// every start, and each job's result, latency and pulse counts are compared to hand-computed values.
module tb_rbm_iteration_scheduler;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  iter_cfg;
  logic        layer_reset;
  logic        layer_start;
  logic        layer_sel;
  logic        layer_done;
  logic [23:0] layer_out;
  logic [23:0] out_data;
  logic [0:0]  class_idx;
  logic        out_valid;
  logic        out_ready;
  logic        error;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int n_reset = 0;
  int n_hstart = 0;
  int n_cstart = 0;
  logic eng_en;
  logic start_seen;

  rbm_iteration_scheduler #(
    .bitlength(12), .output_dim(2), .idx_width(1), .Inf(12'b0111_1111_1111),
    .iter_width(8), .timeout_cycles(16)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .iter_cfg(iter_cfg), .layer_reset(layer_reset), .layer_start(layer_start),
    .layer_sel(layer_sel), .layer_done(layer_done), .layer_out(layer_out),
    .out_data(out_data), .class_idx(class_idx), .out_valid(out_valid),
    .out_ready(out_ready), .error(error), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Engine model: raises layer_done for one cycle, one cycle after each start pulse.
  initial begin
    start_seen = 1'b0;
    layer_done = 1'b0;
    forever begin
      @(negedge clock);
      layer_done = eng_en && start_seen;
      start_seen = layer_start;
      if (layer_reset) n_reset++;
      if (layer_start && !layer_sel) n_hstart++;
      if (layer_start && layer_sel) n_cstart++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: observed hang, expected completion");
    $fatal(1, "[TB] bench timed out");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] iter, input logic [11:0] v0,
                               input logic [11:0] v1, output int cycles);
    layer_out = {v1, v0};
    @(negedge clock);
    iter_cfg = iter;
    in_valid = 1'b1;
    cycles = 0;
    do begin
      @(negedge clock);
      in_valid = 1'b0;
      cycles++;
    end while (!out_valid && cycles < 400);
  endtask

  task automatic finishTransfer(input string tag);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int cyc;
    int r0, h0, c0;
    int stable;
    int guard;
    reset = 1'b1;
    in_valid = 1'b0;
    iter_cfg = 8'd0;
    out_ready = 1'b0;
    layer_out = 24'h0;
    eng_en = 1'b1;

    repeat (2) @(negedge clock);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_layer", {29'd0, layer_reset, layer_start, layer_sel}, 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_err_idx", {30'd0, error, class_idx}, 32'd0);
    reset = 1'b0;

    // Single iteration: {5, -3}
    r0 = n_reset; h0 = n_hstart; c0 = n_cstart;
    applyStimulus(8'd1, 12'd5, 12'hFFD, cyc);
    checkOutput("single_latency", 32'(cyc), 32'd7);
    checkOutput("single_data", 32'(out_data), 32'h00FFD005);
    checkOutput("single_idx", 32'(class_idx), 32'd0);
    checkOutput("single_err", 32'(error), 32'd0);
    checkOutput("single_resets", 32'(n_reset - r0), 32'd1);
    checkOutput("single_hstarts", 32'(n_hstart - h0), 32'd1);
    checkOutput("single_cstarts", 32'(n_cstart - c0), 32'd1);
    finishTransfer("single");

    // Positive saturation: 3 x {1000, -7} -> {2047, -21}
    r0 = n_reset;
    applyStimulus(8'd3, 12'd1000, 12'hFF9, cyc);
    checkOutput("possat_latency", 32'(cyc), 32'd19);
    checkOutput("possat_data", 32'(out_data), 32'h00FEB7FF);
    checkOutput("possat_idx", 32'(class_idx), 32'd0);
    checkOutput("possat_resets", 32'(n_reset - r0), 32'd3);
    finishTransfer("possat");

    // Negative saturation: 2 x {-1500, 4} -> {-2047, 8}
    applyStimulus(8'd2, 12'hA24, 12'd4, cyc);
    checkOutput("negsat_data", 32'(out_data), 32'h00008801);
    checkOutput("negsat_idx", 32'(class_idx), 32'd1);
    checkOutput("negsat_err", 32'(error), 32'd0);
    finishTransfer("negsat");

    // Watchdog: engine silent, DONE 16 cycles after entering H_WAIT
    eng_en = 1'b0;
    applyStimulus(8'd1, 12'd0, 12'd0, cyc);
    checkOutput("timeout_latency", 32'(cyc), 32'd19);
    checkOutput("timeout_err", 32'(error), 32'd1);
    checkOutput("timeout_data", 32'(out_data), 32'd0);
    finishTransfer("timeout");
    eng_en = 1'b1;
    applyStimulus(8'd1, 12'd7, 12'd9, cyc);
    checkOutput("after_to_err", 32'(error), 32'd0);
    checkOutput("after_to_data", 32'(out_data), 32'h00009007);
    checkOutput("after_to_idx", 32'(class_idx), 32'd1);
    finishTransfer("after_to");

    // Backpressure with a tie {-5, -5}; in_valid held high must be ignored
    r0 = n_reset;
    applyStimulus(8'd1, 12'hFFB, 12'hFFB, cyc);
    stable = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (out_valid && out_data == 24'hFFBFFB && class_idx == 1'b0 && !in_ready && busy)
        stable++;
    end
    in_valid = 1'b0;
    checkOutput("hold_stable", 32'(stable), 32'd10);
    checkOutput("hold_no_accept", 32'(n_reset - r0), 32'd1);
    finishTransfer("hold");

    // Reset during C_WAIT of iteration 2
    r0 = n_reset;
    layer_out = {12'd1, 12'd1};
    @(negedge clock);
    iter_cfg = 8'd3;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    guard = 0;
    while (!(layer_sel && !layer_start && (n_reset - r0) == 2) && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    checkOutput("midrst_reached", 32'(guard < 100), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("midrst_idle", {29'd0, in_ready, busy, layer_sel}, 32'h4);
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (!out_valid && !busy) stable++;
    end
    checkOutput("midrst_no_output", 32'(stable), 32'd10);

    // iter_cfg = 0 runs exactly one iteration
    r0 = n_reset;
    applyStimulus(8'd0, 12'd3, 12'd1, cyc);
    checkOutput("zero_iter_latency", 32'(cyc), 32'd7);
    checkOutput("zero_iter_resets", 32'(n_reset - r0), 32'd1);
    checkOutput("zero_iter_data", 32'(out_data), 32'h00001003);
    finishTransfer("zero_iter");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rbm_iteration_scheduler.md
Name: rbm_iteration_scheduler

Overview:
- Sequences one shared RBM layer engine through repeated hidden-phase then classify-phase passes for a fixed number of stochastic iterations.
- Accumulates each iteration's classify output with saturation and reports an argmax class.
- Sits between the input data source and the layer engine, and replaces free-running per-layer iteration loops with an explicit handshake FSM and a watchdog.

Parameters:
- bitlength, 12, width of each signed output element.
- output_dim, 2, number of classify outputs.
- idx_width, 1, width of class_idx (at least ceil(log2(output_dim))).
- Inf, 12'b0111_1111_1111, positive saturation bound; the negative bound is -Inf.
- iter_width, 8, width of iteration count config.
- timeout_cycles, 1024, maximum cycles allowed in any wait state.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  new input vector available; the engine samples the data itself.
- in_ready  output  1  scheduler idle and accepting a job.
- iter_cfg  input  iter_width  iteration count, sampled on job accept.
- layer_reset  output  1  one-cycle clear pulse to the engine before each iteration.
- layer_start  output  1  one-cycle start pulse for the selected phase.
- layer_sel  output  1  phase select: 0 = hidden, 1 = classify; held stable through start and wait.
- layer_done  input  1  engine phase complete; sampled only in wait states.
- layer_out  input  output_dim*bitlength  signed classify result, valid while layer_done=1 in CLASS_WAIT.
- out_data  output  output_dim*bitlength  saturated accumulated sums; element g occupies bits [g*bitlength +: bitlength].
- class_idx  output  idx_width  index of the maximum accumulated element.
- out_valid  output  1  result available; held until out_ready.
- out_ready  input  1  downstream accepts the result.
- error  output  1  watchdog fired on this job; valid with out_valid.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: state=IDLE; in_ready=1 from the first cycle after reset; all other outputs 0; accumulators and counters 0.
- Reset asserted mid-job: abandons the job at the next edge with no output. layer_reset is not pulsed on reset; reset itself clears the engine.
- States: IDLE, CLR, H_START, H_WAIT, C_START, C_WAIT, ACCUM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch target = (iter_cfg==0 ? 1 : iter_cfg), clear acc, iter_cnt, error, class_idx, then go to CLR.
- CLR: layer_reset=1 for one cycle, then H_START.
- H_START: layer_start=1 and layer_sel=0 for one cycle; clear watchdog; go to H_WAIT.
- H_WAIT:
  - layer_sel=0.
  - On layer_done, go to C_START.
  - Watchdog increments every cycle. On reaching timeout_cycles without layer_done: error=1, go to DONE with the current acc.
- C_START: layer_start=1 and layer_sel=1 for one cycle; clear watchdog; go to C_WAIT.
- C_WAIT:
  - Same as H_WAIT with layer_sel=1.
  - On layer_done, register layer_out into an internal sample register and go to ACCUM.
- ACCUM:
  - For each g: acc[g] = clamp(acc[g] + sample[g], -Inf, +Inf).
  - The sum is computed at bitlength+1 bits before clamping; no wrap-around is permitted.
  - iter_cnt++. If iter_cnt == target go to DONE, else go to CLR.
- DONE entry:
  - class_idx = lowest index g with maximum signed acc[g]; ties go to the lower index.
  - out_data = acc.
- DONE:
  - out_valid=1; out_data, class_idx and error are held stable.
  - On out_ready: out_valid drops at the next edge, go to IDLE.
  - out_valid and out_ready high in the same cycle completes the transfer in that cycle.
- Simultaneous events:
  - layer_done during a START cycle is ignored.
  - in_valid outside IDLE is ignored; in_ready=0.
- Latency, engine done in 1 cycle per phase: 6 cycles per iteration (CLR, H_START, H_WAIT, C_START, C_WAIT, ACCUM), plus 1 cycle to DONE.

Test Plan:
- Reset: assert reset 2 cycles with out_ready=0 -> in_ready=1, out_valid=0, busy=0, layer_* =0, out_data=0.
- Single iteration: iter_cfg=1; engine returns layer_out={g0=5, g1=-3} one cycle after each start -> exactly one layer_reset, two starts (sel 0 then 1), out_data={5,-3}, class_idx=0, error=0, out_valid 7 cycles after accept.
- Positive saturation: iter_cfg=3, layer_out={1000,-7} each time -> out_data={2047,-21}, class_idx=0; 3 layer_reset pulses.
- Negative saturation and argmax: iter_cfg=2, layer_out={-1500,4} -> out_data={-2047,8}, class_idx=1.
- Timeout: timeout_cycles=16, layer_done held 0 -> out_valid 16 cycles after entering H_WAIT, error=1, out_data={0,0}; next job has error=0.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles -> out_valid and out_data stable; in_valid ignored.
  - Assert reset during C_WAIT of iteration 2 -> IDLE next cycle, no out_valid.
  - iter_cfg=0 -> runs 1 iteration.
